// File: rtl/xnor_pkg.sv
// Shared definitions for the xnor32 arbitration slice: data width, slot
// encoding and the round-robin search helper.
package xnor_pkg;

    localparam int unsigned XNOR_WIDTH = 32;
    localparam int unsigned RR_MAX     = 8;

    typedef enum logic {
        SlotEmpty = 1'b0,
        SlotFull  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping modulo num.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [2:0]        ptr,
                                         input int unsigned       num);
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            cand = (32'(ptr) + i) % num;
            if (i < num && !res.found && valid[cand[2:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Parameterised round-robin picker with its own pointer register; the pointer
// advances past the winner only on a cycle that actually grants.
module rr_arbiter
    import xnor_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_aL,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    rr_pick_t        pick;

    always_comb begin
        pick        = rr_pick(RR_MAX'(req_valid), 3'(ptr_q), NUM_REQ);
        grant_valid = enable && pick.found;
        grant_id    = ID_W'(pick.idx);
        grant       = '0;
        ptr_d       = ptr_q;
        if (grant_valid) begin
            grant[grant_id] = 1'b1;
            ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/xnor32.sv
// 32-bit XNOR reduction tree; output is 1 when the popcount is even.
module xnor32 (
    input  logic [31:0] a,
    output logic        y
);

    assign y = ~^a;

endmodule

// File: rtl/xnor_reduce_arb.sv
// Shares one xnor32 tree among NUM_REQ valid/ready requesters through a
// single-entry result slot with backpressure and flush.
module xnor_reduce_arb
    import xnor_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst_aL,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    output logic [ID_W-1:0]          resp_id,
    output logic                     resp_xnor,
    input  logic                     resp_ready,
    input  logic                     flush
);

    if (WIDTH != XNOR_WIDTH) begin : g_width_chk
        $error("xnor_reduce_arb: WIDTH must be 32 to match xnor32");
    end
    if (NUM_REQ < 2 || NUM_REQ > RR_MAX) begin : g_num_chk
        $error("xnor_reduce_arb: NUM_REQ must be 2..8");
    end
    if (ID_W != $clog2(NUM_REQ)) begin : g_id_chk
        $error("xnor_reduce_arb: ID_W must equal clog2(NUM_REQ)");
    end

    slot_state_e     state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            can_accept;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic            xnor_out;

    // A full slot can take a new word only when it drains in the same cycle.
    assign can_accept = !flush && (state_q == SlotEmpty || resp_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst_aL      (rst_aL),
        .req_valid   (req_valid),
        .enable      (can_accept),
        .grant       (req_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        if (flush) begin
            state_d = SlotEmpty;
        end else if (grant_valid) begin
            state_d = SlotFull;
            data_d  = req_data[32'(grant_id) * WIDTH +: WIDTH];
            id_d    = grant_id;
        end else if (state_q == SlotFull && resp_ready) begin
            state_d = SlotEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q <= SlotEmpty;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    xnor32 u_xnor32 (
        .a (data_q),
        .y (xnor_out)
    );

    assign resp_valid = (state_q == SlotFull);
    assign resp_id    = id_q;
    // Gated so an empty slot (including reset, where data is zero) reads as 0.
    assign resp_xnor  = resp_valid & xnor_out;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_aL)
        $onehot0(req_ready));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_aL)
        (resp_valid && !resp_ready && !flush) |=>
            (resp_valid && $stable(data_q) && $stable(id_q)));

    a_flush_empties: assert property (@(posedge clk) disable iff (!rst_aL)
        flush |=> !resp_valid);

endmodule

// File: tb/tb_xnor_reduce_arb.sv
// Self-checking bench for xnor_reduce_arb: directed scenarios plus a random
// phase, all checked every cycle against a behavioural slot/arbiter model.
module tb_xnor_reduce_arb;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_aL = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic [1:0]     resp_id;
    logic           resp_xnor;
    logic           resp_ready = 1'b0;
    logic           flush = 1'b0;
    logic [31:0]    words [N];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic         m_full = 1'b0;
    int           m_id = 0;
    logic [31:0]  m_word = '0;
    int           m_ptr = 0;
    logic [N-1:0] m_last_grant = '0;
    logic [N-1:0] m_ready;
    int           m_win;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_data[g*W +: W] = words[g];
    end

    xnor_reduce_arb #(
        .NUM_REQ (N),
        .ID_W    (2),
        .WIDTH   (W)
    ) dut (
        .clk        (clk),
        .rst_aL     (rst_aL),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_xnor  (resp_xnor),
        .resp_ready (resp_ready),
        .flush      (flush)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready(input int win, input logic fl,
                                                 input logic rr, input logic full);
        logic [N-1:0] r;
        r = '0;
        if (!fl && (!full || rr) && win >= 0) r[win] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] even_parity(input logic [31:0] w);
        return 32'(($countones(w) % 2) == 0);
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(3))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h1 << $urandom_range(31);
            default: return $urandom;
        endcase
    endfunction

    always_comb begin
        m_win   = pick_winner(req_valid, m_ptr);
        m_ready = model_ready(m_win, flush, resp_ready, m_full);
    end

    always @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            m_full       <= 1'b0;
            m_id         <= 0;
            m_word       <= '0;
            m_ptr        <= 0;
            m_last_grant <= '0;
        end else begin
            m_last_grant <= m_ready;
            if (flush) begin
                m_full <= 1'b0;
            end else if (m_ready != '0) begin
                m_full <= 1'b1;
                m_id   <= m_win;
                m_word <= words[m_win];
                m_ptr  <= (m_win + 1) % N;
            end else if (m_full && resp_ready) begin
                m_full <= 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_aL) begin
            check("model_req_ready", 32'(req_ready), 32'(m_ready));
            check("model_resp_valid", 32'(resp_valid), 32'(m_full));
            if (m_full) begin
                check("model_resp_id", 32'(resp_id), 32'(m_id));
                check("model_resp_xnor", 32'(resp_xnor), even_parity(m_word));
            end else begin
                check("model_resp_xnor_idle", 32'(resp_xnor), 32'h0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int exp_g [5] = '{0, 1, 2, 3, 0};
    int exp_x [4] = '{0, 1, 0, 1};

    initial begin
        for (int i = 0; i < N; i++) words[i] = '0;
        #1 rst_aL = 1'b0;
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_id", 32'(resp_id), 32'h0);
        check("rst_resp_xnor", 32'(resp_xnor), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_aL = 1'b1;

        // 1: single request, zero word
        req_valid = 4'b0001; resp_ready = 1'b1;
        @(negedge clk);
        check("t1_grant", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = 4'b1111;
        @(negedge clk);
        check("t1_resp_valid", 32'(resp_valid), 32'h1);
        check("t1_resp_id", 32'(resp_id), 32'h0);
        check("t1_resp_xnor", 32'(resp_xnor), 32'h1);
        check("t1_ptr_next", 32'(req_ready), 32'h2);
        next_cycle();
        rst_aL = 1'b0; req_valid = '0;
        next_cycle();
        rst_aL = 1'b1;

        // 2: all valid, round-robin order and parity
        words[0] = 32'h1; words[1] = 32'h3; words[2] = 32'h7; words[3] = 32'hFFFF_FFFF;
        req_valid = 4'b1111; resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_grant", 32'(req_ready), 32'h1 << exp_g[k]);
            if (k > 0) begin
                check("t2_resp_id", 32'(resp_id), 32'(exp_g[k-1]));
                check("t2_resp_xnor", 32'(resp_xnor), 32'(exp_x[exp_g[k-1]]));
            end
            next_cycle();
        end

        // 3: backpressure holds everything, then back-to-back
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold_ready", 32'(req_ready), 32'h0);
            check("t3_hold_valid", 32'(resp_valid), 32'h1);
            check("t3_hold_id", 32'(resp_id), 32'h0);
            check("t3_hold_xnor", 32'(resp_xnor), 32'h0);
            next_cycle();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("t3_release_grant", 32'(req_ready), 32'h2);
        next_cycle();
        @(negedge clk);
        check("t3_b2b_id", 32'(resp_id), 32'h1);
        check("t3_b2b_xnor", 32'(resp_xnor), 32'h1);
        check("t3_b2b_grant", 32'(req_ready), 32'h4);
        next_cycle();

        // 4: pointer at 3 wraps to 0
        req_valid = 4'b1001; words[3] = 32'h8000_0003; words[0] = 32'h0;
        @(negedge clk);
        check("t4_grant3", 32'(req_ready), 32'h8);
        next_cycle();
        req_valid = 4'b0001;
        @(negedge clk);
        check("t4_wrap_grant0", 32'(req_ready), 32'h1);
        check("t4_resp_id", 32'(resp_id), 32'h3);
        check("t4_resp_xnor", 32'(resp_xnor), 32'h0);
        next_cycle();

        // 5: flush while full
        req_valid = 4'b0010; flush = 1'b1; resp_ready = 1'b0;
        @(negedge clk);
        check("t5_flush_no_grant", 32'(req_ready), 32'h0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("t5_after_flush_valid", 32'(resp_valid), 32'h0);
        check("t5_after_flush_grant", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("t5_result_id", 32'(resp_id), 32'h1);
        check("t5_result_valid", 32'(resp_valid), 32'h1);

        // 6: asynchronous reset mid-cycle while full
        @(negedge clk);
        #2 rst_aL = 1'b0;
        #1;
        check("t6_async_valid", 32'(resp_valid), 32'h0);
        check("t6_async_xnor", 32'(resp_xnor), 32'h0);
        next_cycle();
        rst_aL = 1'b1; req_valid = 4'b1111; resp_ready = 1'b1;
        @(negedge clk);
        check("t6_first_grant", 32'(req_ready), 32'h1);
        next_cycle();

        // Random phase
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) rst_aL = 1'b0;
            if (c == 1501) rst_aL = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (m_last_grant[i]) req_valid[i] = 1'b0;
                if (req_valid[i] && $urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_valid[i] = 1'b1;
                    words[i] = rand_word();
                end
            end
            resp_ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(31) == 0);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
